// File: rtl/dmux_stream_nway.sv
// dmux_stream_nway: 1-to-NCH stream demultiplexer with a valid/ready handshake.
// Every output channel has a one-entry holding register. The target channel
// comes either from sel or from an internal round-robin pointer.
// A channel's data reads zero whenever its valid bit is clear.

module dmux_stream_nway #(
  parameter int WIDTH = 16,
  parameter int NCH   = 4,
  parameter int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic [NCH-1:0]       out_valid,
  input  logic [NCH-1:0]       out_ready,
  output logic [SELW-1:0]      cur_ch,
  output logic                 sel_err
);

  // NCH is widened by one bit so that sel values that cannot name a channel
  // compare correctly when NCH is not a power of two.
  localparam logic [SELW:0]   NchExt = (SELW+1)'(NCH);
  localparam logic [SELW-1:0] LastCh = SELW'(NCH-1);

  logic [SELW-1:0]      target;
  logic [SELW-1:0]      rrPtr_q, rrPtr_d;
  logic [NCH-1:0]       valid_q, valid_d;
  logic [NCH-1:0]       tgtOneHot;
  logic [NCH*WIDTH-1:0] data_q, data_d;
  logic                 selErr;
  logic                 accept;

  // Pick the target channel and decide whether the producer may hand over a beat.
  // An illegal sel gives an all-zero one-hot, so nothing can be accepted.
  always_comb begin
    target    = mode ? rrPtr_q : sel;
    selErr    = !mode && ({1'b0, sel} >= NchExt);
    tgtOneHot = '0;
    for (int i = 0; i < NCH; i++) begin
      tgtOneHot[i] = (SELW'(i) == target);
    end
    in_ready = !selErr && (|(tgtOneHot & (~valid_q | out_ready)));
    accept   = in_valid && in_ready;
  end

  // Next state: drains clear a channel, then an accept reloads the target.
  // Placing the load after the drain lets a full channel take a beat every cycle.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    rrPtr_d = rrPtr_q;
    for (int i = 0; i < NCH; i++) begin
      if (valid_q[i] && out_ready[i]) begin
        valid_d[i]                = 1'b0;
        data_d[i*WIDTH +: WIDTH]  = '0;
      end
      if (accept && tgtOneHot[i]) begin
        valid_d[i]                = 1'b1;
        data_d[i*WIDTH +: WIDTH]  = in_data;
      end
    end
    if (accept && mode) begin
      rrPtr_d = (rrPtr_q == LastCh) ? '0 : rrPtr_q + 1'b1;
    end
  end

  // Holding registers and round-robin pointer. Reset discards any held beats.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      data_q  <= '0;
      rrPtr_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      rrPtr_q <= rrPtr_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign cur_ch    = target;
  assign sel_err   = selErr;

endmodule
